// File: rtl/text_renderer.sv
// Text-mode pixel pipeline: per 8-pixel cell it fetches char, attribute and font row, then shifts out 8 colour indices.
// Optional: define TEXT_RENDERER_BLINK_EN to turn attr[7] into a blink flag driven by a vSync frame counter.
module text_renderer #(
    parameter int COLS      = 80,
    parameter int ROWS      = 30,
    parameter int ATTR_BASE = 4096,
    parameter int LATENCY   = 8
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        activeIn,
    input  logic        hSyncIn,
    input  logic        vSyncIn,
    output logic [12:0] vramRdAddr,
    input  logic [7:0]  vramRdData,
    output logic [11:0] fontAddr,
    input  logic [7:0]  fontData,
    output logic [3:0]  pixColor,
    output logic        activeOut,
    output logic        hSyncOut,
    output logic        vSyncOut
);
    localparam logic [2:0]  PH_CHAR  = 3'd0;
    localparam logic [2:0]  PH_ATTR  = 3'd1;
    localparam logic [2:0]  PH_FONT  = 3'd2;
    localparam logic [2:0]  PH_LATCH = 3'd3;
    localparam logic [2:0]  PH_LOAD  = 3'd7;
    localparam logic [6:0]  COLS_W   = 7'(COLS);
    localparam logic [5:0]  ROWS_W   = 6'(ROWS);
    localparam logic [12:0] ATTR_W   = 13'(ATTR_BASE);
    // Reset values of the {vSync, hSync, active} delay lines.
    localparam logic [2:0]  DLY_RST  = 3'b110;

    logic [2:0]  phase;
    logic [6:0]  col;
    logic [5:0]  row;
    logic [3:0]  cellLine;
    logic        inRange;
    logic [12:0] cellAddr;
    logic [12:0] attrAddr;

    logic        cellValid;
    logic [7:0]  charReg;
    logic [7:0]  attrReg;
    logic [7:0]  bitsReg;
    logic [7:0]  shiftReg;
    logic [7:0]  attrOut;
    logic [3:0]  fgColor;
    logic [3:0]  bgColor;
    logic [2:0]  dlyIn;

    assign phase    = hCount[2:0];
    assign col      = hCount[9:3];
    assign row      = vCount[9:4];
    assign cellLine = vCount[3:0];
    assign inRange  = activeIn && (col < COLS_W) && (row < ROWS_W);
    assign cellAddr = 13'(row) * 13'(COLS) + 13'(col);
    assign attrAddr = cellAddr + ATTR_W;

    // Phase is always taken from hCount, so a jump in hCount re-aligns the fetch sequence.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            vramRdAddr <= '0;
            fontAddr   <= '0;
            cellValid  <= 1'b0;
            charReg    <= '0;
            attrReg    <= '0;
            bitsReg    <= '0;
            shiftReg   <= '0;
            attrOut    <= '0;
        end else begin
            case (phase)
                PH_CHAR: begin
                    cellValid <= inRange;
                    if (inRange) vramRdAddr <= cellAddr;
                end
                PH_ATTR: begin
                    charReg <= vramRdData;
                    if (cellValid) vramRdAddr <= attrAddr;
                end
                PH_FONT: begin
                    attrReg <= vramRdData;
                    if (cellValid) fontAddr <= {charReg, cellLine};
                end
                PH_LATCH: bitsReg <= fontData;
                default: ;
            endcase

            // Loading on PH7 puts the cell's first pixel out exactly one cell after its PH0.
            if (phase == PH_LOAD) begin
                shiftReg <= cellValid ? bitsReg : 8'h00;
                attrOut  <= cellValid ? attrReg : 8'h00;
            end else begin
                shiftReg <= {shiftReg[6:0], 1'b0};
            end
        end
    end

    assign dlyIn = {vSyncIn, hSyncIn, activeIn};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dly
            logic [LATENCY-1:0] dly;
            always_ff @(posedge clk) begin
                if (!nrst) dly <= {LATENCY{DLY_RST[gi]}};
                else       dly <= {dly[LATENCY-2:0], dlyIn[gi]};
            end
        end
    endgenerate

    assign activeOut = g_dly[0].dly[LATENCY-1];
    assign hSyncOut  = g_dly[1].dly[LATENCY-1];
    assign vSyncOut  = g_dly[2].dly[LATENCY-1];

`ifdef TEXT_RENDERER_BLINK_EN
    logic       vSyncPrev;
    logic [4:0] frameCnt;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            vSyncPrev <= 1'b1;
            frameCnt  <= '0;
        end else begin
            vSyncPrev <= vSyncIn;
            if (vSyncPrev && !vSyncIn) frameCnt <= frameCnt + 5'd1;
        end
    end

    assign bgColor = {1'b0, attrOut[6:4]};
    assign fgColor = (frameCnt[4] && attrOut[7]) ? bgColor : attrOut[3:0];
`else
    assign bgColor = attrOut[7:4];
    assign fgColor = attrOut[3:0];
`endif

    assign pixColor = activeOut ? (shiftReg[7] ? fgColor : bgColor) : 4'd0;

endmodule

// File: tb/tb_text_renderer.sv
// Bench for text_renderer: random VRAM/font contents, raster stimulus, and a cell-level colour model
// whose expectations are delayed 8 clks in a queue to line up with the DUT outputs.
module tb_text_renderer;
    localparam int LAT = 8;

    typedef struct packed {
        logic [3:0] color;
        logic       act;
        logic       hs;
        logic       vs;
    } outs_t;

    localparam outs_t IDLE = 7'b0000011;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [9:0]  hCount = '0;
    logic [9:0]  vCount = '0;
    logic        activeIn = 1'b0;
    logic        hSyncIn = 1'b1;
    logic        vSyncIn = 1'b1;
    logic [12:0] vramRdAddr;
    logic [7:0]  vramRdData;
    logic [11:0] fontAddr;
    logic [7:0]  fontData;
    logic [3:0]  pixColor;
    logic        activeOut;
    logic        hSyncOut;
    logic        vSyncOut;

    logic [7:0] vram [0:8191];
    logic [7:0] font [0:4095];

    int    checks = 0;
    int    errors = 0;
    outs_t expQ[$];
    bit    seenPh0 = 1'b0;
`ifdef TEXT_RENDERER_BLINK_EN
    logic  prevVs = 1'b1;
    int    frameFalls = 0;
`endif

    text_renderer dut (
        .clk        (clk),
        .nrst       (nrst),
        .hCount     (hCount),
        .vCount     (vCount),
        .activeIn   (activeIn),
        .hSyncIn    (hSyncIn),
        .vSyncIn    (vSyncIn),
        .vramRdAddr (vramRdAddr),
        .vramRdData (vramRdData),
        .fontAddr   (fontAddr),
        .fontData   (fontData),
        .pixColor   (pixColor),
        .activeOut  (activeOut),
        .hSyncOut   (hSyncOut),
        .vSyncOut   (vSyncOut)
    );

    // Memories answer within the cycle after the address register changes.
    assign vramRdData = vram[vramRdAddr];
    assign fontData   = font[fontAddr];

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [3:0] model(input logic [9:0] h, input logic [9:0] v, input logic act);
        int col, row, ln, idx;
        logic [7:0] ch, at, fr;
        logic [3:0] fg, bg;
        col = int'(h) / 8;
        row = int'(v) / 16;
        ln  = int'(v) % 16;
        if (!act || !seenPh0 || col >= 80 || row >= 30) return 4'd0;
        idx = row * 80 + col;
        ch  = vram[idx % 8192];
        at  = vram[(4096 + idx) % 8192];
        fr  = font[int'(ch) * 16 + ln];
        fg  = at[3:0];
        bg  = at[7:4];
`ifdef TEXT_RENDERER_BLINK_EN
        bg = {1'b0, at[6:4]};
        if (at[7] && (frameFalls % 32) >= 16) fg = bg;
`endif
        return fr[7 - (int'(h) % 8)] ? fg : bg;
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < 8192; i++) vram[i] = 8'($urandom);
        for (int i = 0; i < 4096; i++) font[i] = 8'($urandom);
    endtask

    // One pixel clock: observe current outputs, pop their expectation, drive new inputs, push theirs.
    task automatic tick(input logic [9:0] h, input logic [9:0] v, input logic act,
                        input logic hs, input logic vs, output outs_t obs, output outs_t want);
        obs  = {pixColor, activeOut, hSyncOut, vSyncOut};
        want = expQ.pop_front();
        hCount = h; vCount = v; activeIn = act; hSyncIn = hs; vSyncIn = vs;
        if (nrst) begin
            if (h[2:0] == 3'd0) seenPh0 = 1'b1;
`ifdef TEXT_RENDERER_BLINK_EN
            if (prevVs && !vs) frameFalls++;
            prevVs = vs;
`endif
        end
        expQ.push_back({model(h, v, act), act, hs, vs});
        @(posedge clk);
        if (!nrst) begin
            expQ.delete();
            repeat (LAT) expQ.push_back(IDLE);
            seenPh0 = 1'b0;
`ifdef TEXT_RENDERER_BLINK_EN
            prevVs = 1'b1;
            frameFalls = 0;
`endif
        end
        #1;
    endtask

    task automatic idle(input int n);
        outs_t obs, want;
        for (int k = 0; k < n; k++) tick(10'd648, 10'd0, 1'b0, 1'b1, 1'b1, obs, want);
    endtask

    task automatic test_reset();
        outs_t obs, want;
        logic [9:0] v;
        nrst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(10'($urandom_range(0, 799)), 10'($urandom_range(0, 479)), 1'b1,
                 1'($urandom), 1'($urandom), obs, want);
            if (k > 0) begin
                checks++;
                if (obs !== IDLE) begin
                    errors++;
                    $display("FAIL reset_hold cyc %0d got %h want %h", k, obs, IDLE);
                end
            end
        end
        nrst = 1'b1;
        v = 10'($urandom_range(0, 479));
        for (int k = 0; k < 40; k++) begin
            tick(10'(k), v, k < 32, 1'b1, 1'b1, obs, want);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL reset_release cyc %0d got %h want %h", k, obs, want);
            end
            if (k < 8) begin
                checks++;
                if (obs !== IDLE) begin
                    errors++;
                    $display("FAIL reset_refill cyc %0d got %h want %h", k, obs, IDLE);
                end
            end
        end
        $display("test_reset: line %0d rendered after release", v);
    endtask

    task automatic test_single_cell();
        outs_t obs, want;
        logic [3:0] pixWant [8];
        pixWant = '{4'hE, 4'h1, 4'hE, 4'h1, 4'h1, 4'hE, 4'h1, 4'hE};
        idle(4);
        vram[0] = 8'h41; vram[4096] = 8'h1E; font[12'h410] = 8'hA5;
        for (int k = 0; k < 24; k++) begin
            tick(10'(k), 10'd0, k < 16, 1'b1, 1'b1, obs, want);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL single_cell cyc %0d got %h want %h", k, obs, want);
            end
            if (k == 0) begin
                checks++;
                if (vramRdAddr !== 13'd0) begin
                    errors++;
                    $display("FAIL single_char_addr got %0d want 0", vramRdAddr);
                end
            end
            if (k == 1) begin
                checks++;
                if (vramRdAddr !== 13'd4096) begin
                    errors++;
                    $display("FAIL single_attr_addr got %0d want 4096", vramRdAddr);
                end
            end
            if (k == 2) begin
                checks++;
                if (fontAddr !== 12'h410) begin
                    errors++;
                    $display("FAIL single_font_addr got %h want 410", fontAddr);
                end
            end
            if (k >= 8 && k < 16) begin
                checks++;
                if (obs.color !== pixWant[k - 8]) begin
                    errors++;
                    $display("FAIL single_pixel %0d got %h want %h", k - 8, obs.color, pixWant[k - 8]);
                end
            end
        end
        $display("test_single_cell: cell (0,0) char 41 attr 1E font A5");
    endtask

    task automatic test_address_math();
        outs_t obs, want;
        for (int k = 0; k < 32; k++) begin
            tick(10'(624 + k), 10'd479, (624 + k) < 640, 1'b1, 1'b1, obs, want);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL addr_math_pix h %0d got %h want %h", 624 + k, obs, want);
            end
            if (624 + k == 632) begin
                checks++;
                if (vramRdAddr !== 13'd2399) begin
                    errors++;
                    $display("FAIL addr_math_char got %0d want 2399", vramRdAddr);
                end
            end
            if (624 + k == 633) begin
                checks++;
                if (vramRdAddr !== 13'd6495) begin
                    errors++;
                    $display("FAIL addr_math_attr got %0d want 6495", vramRdAddr);
                end
            end
        end
        $display("test_address_math: cell (79,29)");
    endtask

    task automatic test_out_of_range();
        outs_t obs, want;
        logic [12:0] prevAddr;
        logic [9:0] v;
        v = 10'($urandom_range(0, 479));
        for (int seg = 0; seg < 2; seg++) begin
            for (int k = 0; k < 24; k++) begin
                logic [9:0] h;
                logic act;
                h   = (seg == 0) ? 10'(632 + k) : 10'(k);
                act = (seg == 0) ? (k < 16) : (k < 8);
                prevAddr = vramRdAddr;
                tick(h, (seg == 0) ? v : 10'd480, act, 1'b1, 1'b1, obs, want);
                checks++;
                if (obs !== want) begin
                    errors++;
                    $display("FAIL oor_pix seg %0d h %0d got %h want %h", seg, h, obs, want);
                end
                if (act && ((seg == 0 && h >= 640) || seg == 1)) begin
                    checks++;
                    if (vramRdAddr !== prevAddr) begin
                        errors++;
                        $display("FAIL oor_addr seg %0d h %0d got %0d want %0d", seg, h, vramRdAddr, prevAddr);
                    end
                end
            end
        end
        $display("test_out_of_range: col 80 on line %0d, row 30", v);
    endtask

    task automatic test_sync_alignment();
        outs_t obs, want;
        int t, firstLow;
        logic [9:0] v;
        t = 20 + int'($urandom_range(0, 7));
        v = 10'($urandom_range(0, 479));
        firstLow = -1;
        for (int k = 0; k < 64; k++) begin
            tick(10'(k), v, k < 40, !(k >= t && k < t + 6), 1'b1, obs, want);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL sync_pix cyc %0d got %h want %h", k, obs, want);
            end
            if (firstLow < 0 && obs.hs === 1'b0) firstLow = k;
        end
        checks++;
        if (firstLow !== t + LAT) begin
            errors++;
            $display("FAIL sync_align hSyncOut fell at %0d want %0d", firstLow, t + LAT);
        end
        $display("test_sync_alignment: hSyncIn fell at %0d", t);
    endtask

    task automatic test_midreset();
        outs_t obs, want;
        logic [9:0] v;
        v = 10'($urandom_range(0, 479));
        for (int k = 0; k < 64; k++) begin
            nrst = !(k == 19 || k == 20);
            tick(10'(k), v, k < 48, 1'b1, 1'b1, obs, want);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL midreset cyc %0d got %h want %h", k, obs, want);
            end
        end
        nrst = 1'b1;
        $display("test_midreset: line %0d reset at h 19..20", v);
    endtask

    task automatic test_random_frame();
        outs_t obs, want;
        idle(4);
        fill_mem();
        for (int ln = 0; ln < 6; ln++) begin
            logic [9:0] v;
            v = 10'($urandom_range(0, 479));
            for (int h = 0; h < 800; h++) begin
                tick(10'(h), v, h < 640, !(h >= 656 && h < 752), 1'b1, obs, want);
                checks++;
                if (obs !== want) begin
                    errors++;
                    $display("FAIL random_frame line %0d h %0d got %h want %h", v, h, obs, want);
                end
            end
            $display("test_random_frame: line %0d", v);
        end
    endtask

`ifdef TEXT_RENDERER_BLINK_EN
    task automatic test_blink();
        outs_t obs, want;
        logic [3:0] colWant;
        nrst = 1'b0;
        idle(2);
        nrst = 1'b1;
        vram[0] = 8'h5A; vram[4096] = 8'h9F; font[12'h5A0] = 8'hFF;
        for (int p = 0; p < 3; p++) begin
            if (p > 0) begin
                for (int f = 0; f < 16; f++) begin
                    for (int s = 0; s < 4; s++) begin
                        tick(10'd648, 10'd0, 1'b0, 1'b1, s < 2, obs, want);
                        checks++;
                        if (obs !== want) begin
                            errors++;
                            $display("FAIL blink_vsync got %h want %h", obs, want);
                        end
                    end
                end
            end
            colWant = (p == 1) ? 4'h1 : 4'hF;
            for (int k = 0; k < 24; k++) begin
                tick(10'(k), 10'd0, k < 8, 1'b1, 1'b1, obs, want);
                checks++;
                if (obs !== want) begin
                    errors++;
                    $display("FAIL blink_pix pass %0d cyc %0d got %h want %h", p, k, obs, want);
                end
                if (k >= 8 && k < 16) begin
                    checks++;
                    if (obs.color !== colWant) begin
                        errors++;
                        $display("FAIL blink_color pass %0d px %0d got %h want %h", p, k - 8, obs.color, colWant);
                    end
                end
            end
            $display("test_blink: after %0d vSync falls", 16 * p);
        end
    endtask
`endif

    initial begin
        repeat (LAT) expQ.push_back(IDLE);
        fill_mem();
        test_reset();
        test_single_cell();
        test_address_math();
        test_out_of_range();
        test_sync_alignment();
        test_midreset();
        test_random_frame();
`ifdef TEXT_RENDERER_BLINK_EN
        test_blink();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
